// File: rtl/ref_wb_drain_ctrl.sv
// ref_wb_drain_ctrl: collects per-PE reference writebacks, waits for the ring to drain,
// then releases either the next reference particle or motion update.
module ref_wb_drain_ctrl #(
  parameter int NUM_CELLS    = 64,
  parameter int DRAIN_CYCLES = NUM_CELLS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CELLS-1:0]            ref_wb_issued,
  input  logic [NUM_CELLS-1:0]            force_valid,
  input  logic [NUM_CELLS-1:0]            force_wr_enable,
  input  logic                            force_cache_input_buffer_empty,
  input  logic                            all_filter_buffer_empty,
  input  logic                            all_reading_done,
  input  logic                            mu_done,
  output logic                            all_ref_wb_issued,
  output logic                            interconnect_empty,
  output logic                            goto_next_ref,
  output logic                            motion_update_start,
  output logic [$clog2(DRAIN_CYCLES):0]   drain_count,
  output logic                            wb_protocol_err
);
  localparam int CW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CW-1:0] DC = CW'(DRAIN_CYCLES);
  typedef enum logic [1:0] {COLLECT, DRAIN, DECIDE, MU_RUN} state_t;
  state_t state_q, state_d;
  logic [NUM_CELLS-1:0] cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic all_q, all_d, ie_q, ie_d, goto_q, goto_d, mus_q, mus_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    all_d   = all_q;
    cnt_d   = cnt_q;
    goto_d  = 1'b0;
    mus_d   = 1'b0;
    err_d   = err_q | ((state_q != COLLECT) && (|ref_wb_issued));
    case (state_q)
      COLLECT: begin
        cap_d   = cap_q | ref_wb_issued;
        all_d   = &cap_d;
        cnt_d   = '0;
        state_d = all_q ? DRAIN : COLLECT;
      end
      DRAIN: begin
        // any ring traffic restarts the idle window; the count saturates at DC
        cnt_d   = (|force_valid || |force_wr_enable) ? '0 : (cnt_q == DC) ? cnt_q : cnt_q + 1'b1;
        state_d = (cnt_q == DC && force_cache_input_buffer_empty && all_filter_buffer_empty) ? DECIDE : DRAIN;
      end
      DECIDE: begin
        cap_d   = '0;
        all_d   = 1'b0;
        cnt_d   = '0;
        goto_d  = ~all_reading_done;
        mus_d   = all_reading_done;
        state_d = all_reading_done ? MU_RUN : COLLECT;
      end
      default: state_d = mu_done ? COLLECT : MU_RUN;
    endcase
    ie_d = (cnt_d == DC);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      cap_q   <= '0;
      cnt_q   <= '0;
      all_q   <= 1'b0;
      ie_q    <= 1'b0;
      goto_q  <= 1'b0;
      mus_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      all_q   <= all_d;
      ie_q    <= ie_d;
      goto_q  <= goto_d;
      mus_q   <= mus_d;
      err_q   <= err_d;
    end
  end
  assign all_ref_wb_issued   = all_q;
  assign interconnect_empty  = ie_q;
  assign goto_next_ref       = goto_q;
  assign motion_update_start = mus_q;
  assign drain_count         = cnt_q;
  assign wb_protocol_err     = err_q;
endmodule
